// File: rtl/aes_job_scheduler_pkg.sv
// Shared state encodings, default widths and a width helper for the AES job scheduler.
package aes_job_scheduler_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 12;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ISSUE    = 3'd1;
    localparam logic [2:0] S_BUSY     = 3'd2;
    localparam logic [2:0] S_COMPLETE = 3'd3;
    localparam logic [2:0] S_ABORT    = 3'd4;

    // Number of bits needed to index 'value' distinct items.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((32'd1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/aes_job_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
module aes_job_scheduler_rr_arbiter
    import aes_job_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]        req,
    input  logic [clog2(NUM_REQ)-1:0] last_grant,
    output logic [clog2(NUM_REQ)-1:0] grant_c,
    output logic                      valid_c
);

    localparam int unsigned IDX_W = clog2(NUM_REQ);

    logic [IDX_W-1:0] cand_c;

    // Walk from the farthest offset to the nearest so the nearest request wins.
    always_comb begin
        grant_c = '0;
        cand_c  = '0;
        valid_c = |req;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand_c = IDX_W'((32'(last_grant) + NUM_REQ - i) % NUM_REQ);
            if (req[cand_c]) begin
                grant_c = cand_c;
            end
        end
    end

endmodule

// File: rtl/aes_job_scheduler.sv
// Shares one AES accelerator between requesters: round-robin grant, start/done
// handshake, watchdog abort and key-ownership tracking.
module aes_job_scheduler
    import aes_job_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_new_key,
    input  logic [NUM_REQ*ADDR_W-1:0] req_plain_addr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_cipher_addr,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        job_done,
    output logic [NUM_REQ-1:0]        job_timeout,
    output logic                      busy,
    output logic [clog2(NUM_REQ)-1:0] owner,
    output logic                      acc_start,
    output logic                      acc_new_key,
    output logic [ADDR_W-1:0]         acc_plain_address,
    output logic [ADDR_W-1:0]         acc_cipher_address,
    input  logic                      acc_done
);

    localparam int unsigned      IDX_W    = clog2(NUM_REQ);
    localparam int unsigned      TMR_W    = clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    logic [2:0]        state, state_nxt;
    logic [IDX_W-1:0]  last_grant, key_owner, grant_c;
    logic              grant_valid_c, key_valid, acc_done_q;
    logic [TMR_W-1:0]  timer;
    logic              done_rise_c, expire_c, take_grant_c;
    logic [ADDR_W-1:0] plain_sel_c, cipher_sel_c;

    aes_job_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req        (req),
        .last_grant (last_grant),
        .grant_c    (grant_c),
        .valid_c    (grant_valid_c)
    );

    // Address slices of the requester currently winning arbitration.
    always_comb begin
        plain_sel_c  = '0;
        cipher_sel_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_c == IDX_W'(i)) begin
                plain_sel_c  = req_plain_addr[i*ADDR_W +: ADDR_W];
                cipher_sel_c = req_cipher_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Done beats the watchdog when both happen in the same BUSY cycle.
    always_comb begin
        done_rise_c  = acc_done & ~acc_done_q;
        expire_c     = (timer == TMR_LAST);
        take_grant_c = (state == S_IDLE) && grant_valid_c;
        state_nxt    = state;
        case (state)
            S_IDLE:     if (grant_valid_c) state_nxt = S_ISSUE;
            S_ISSUE:    state_nxt = S_BUSY;
            S_BUSY: begin
                if (done_rise_c) begin
                    state_nxt = S_COMPLETE;
                end else if (expire_c) begin
                    state_nxt = S_ABORT;
                end
            end
            S_COMPLETE: state_nxt = S_IDLE;
            S_ABORT:    state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so pulses line up with ISSUE/COMPLETE/ABORT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack                <= '0;
            job_done           <= '0;
            job_timeout        <= '0;
            busy               <= 1'b0;
            owner              <= '0;
            acc_start          <= 1'b0;
            acc_new_key        <= 1'b0;
            acc_plain_address  <= '0;
            acc_cipher_address <= '0;
            last_grant         <= IDX_W'(NUM_REQ - 1);
            key_owner          <= '0;
            key_valid          <= 1'b0;
            timer              <= '0;
            acc_done_q         <= 1'b0;
        end else begin
            acc_done_q  <= acc_done;
            busy        <= (state_nxt != S_IDLE);
            acc_start   <= take_grant_c;
            ack         <= take_grant_c ? (NUM_REQ'(1) << grant_c) : '0;
            job_done    <= (state_nxt == S_COMPLETE) ? (NUM_REQ'(1) << owner) : '0;
            job_timeout <= (state_nxt == S_ABORT) ? (NUM_REQ'(1) << owner) : '0;

            if (state == S_ISSUE) begin
                timer <= '0;
            end else if (state == S_BUSY) begin
                timer <= timer + TMR_W'(1);
            end

            if (take_grant_c) begin
                owner              <= grant_c;
                last_grant         <= grant_c;
                acc_plain_address  <= plain_sel_c;
                acc_cipher_address <= cipher_sel_c;
                acc_new_key        <= req_new_key[grant_c] | ~key_valid | (key_owner != grant_c);
            end

            if (state == S_COMPLETE) begin
                key_owner <= owner;
                key_valid <= 1'b1;
            end else if (state == S_ABORT) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Self-checking bench for aes_job_scheduler using a transaction-level model of
// grant order, key ownership and job completion timing.
module tb_aes_job_scheduler;

    localparam int unsigned TO_CYC = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, req_new_key, ack, job_done, job_timeout;
    logic [23:0] req_plain_addr, req_cipher_addr;
    logic        busy;
    logic [0:0]  owner;
    logic        acc_start, acc_new_key, acc_done;
    logic [11:0] acc_plain_address, acc_cipher_address;

    int checks = 0;
    int errors = 0;

    // Model state: last granted requester, key validity and key owner.
    int m_last;
    bit m_kv;
    int m_ko;

    aes_job_scheduler #(
        .NUM_REQ     (2),
        .ADDR_W      (12),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req                (req),
        .req_new_key        (req_new_key),
        .req_plain_addr     (req_plain_addr),
        .req_cipher_addr    (req_cipher_addr),
        .ack                (ack),
        .job_done           (job_done),
        .job_timeout        (job_timeout),
        .busy               (busy),
        .owner              (owner),
        .acc_start          (acc_start),
        .acc_new_key        (acc_new_key),
        .acc_plain_address  (acc_plain_address),
        .acc_cipher_address (acc_cipher_address),
        .acc_done           (acc_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [1:0] rq, input int last);
        int idx;
        for (int i = 1; i <= 2; i++) begin
            idx = (last + i) % 2;
            if (rq[idx[0]]) return idx;
        end
        return 0;
    endfunction

    function automatic logic [1:0] onehot(input int g);
        return (g == 0) ? 2'b01 : 2'b10;
    endfunction

    // One job from an IDLE cycle through to the following IDLE cycle.
    // k: BUSY cycle in which acc_done is driven high (<0 or >=TO_CYC: never).
    // low_from: BUSY cycle in which acc_done is first driven low.
    task automatic run_job(input string name, input logic [1:0] rq, input logic [1:0] nk,
                           input logic [23:0] pl, input logic [23:0] ci,
                           input logic [1:0] rq_busy, input logic [1:0] rq_after,
                           input int k, input int low_from, input bit pulse);
        int          g, term;
        bit          to, exp_nk;
        logic [11:0] pa, ca;
        req             = rq;
        req_new_key     = nk;
        req_plain_addr  = pl;
        req_cipher_addr = ci;
        g      = rr_pick(rq, m_last);
        exp_nk = nk[g[0]] | !m_kv | (m_ko != g);
        pa     = (g == 0) ? pl[11:0] : pl[23:12];
        ca     = (g == 0) ? ci[11:0] : ci[23:12];
        @(posedge clk); #1;
        check({name, "_ack"}, ack, onehot(g));
        check({name, "_issue"}, {busy, acc_start, owner, acc_new_key}, {1'b1, 1'b1, g[0], exp_nk});
        check({name, "_addr"}, {acc_plain_address, acc_cipher_address}, {pa, ca});
        m_last = g;
        to     = !(k >= 0 && k < int'(TO_CYC));
        term   = to ? int'(TO_CYC) : k + 1;
        req             = rq_after;
        req_new_key     = 2'($urandom);
        req_plain_addr  = 24'($urandom);
        req_cipher_addr = 24'($urandom);
        for (int c = 0; c <= term; c++) begin
            @(posedge clk); #1;
            if (c < term) begin
                check({name, "_busy"}, {busy, ack, acc_start, job_done, job_timeout}, 8'b1000_0000);
                check({name, "_hold"}, {acc_plain_address, acc_cipher_address, acc_new_key}, {pa, ca, exp_nk});
                if (c == 1) req = rq_after | rq_busy;
                if (c == low_from) acc_done = 1'b0;
                if (c == k) acc_done = 1'b1;
            end else begin
                check({name, "_end"}, {busy, ack, job_done, job_timeout},
                      {1'b1, 2'b00, to ? 2'b00 : onehot(g), to ? onehot(g) : 2'b00});
                req = rq_after;
                if (pulse) acc_done = 1'b0;
            end
        end
        if (to) begin
            m_kv = 1'b0;
        end else begin
            m_kv = 1'b1;
            m_ko = g;
        end
        @(posedge clk); #1;
        check({name, "_idle"}, {busy, ack, acc_start, job_done, job_timeout}, 8'h00);
    endtask

    initial begin
        rst_n           = 1'b0;
        req             = '0;
        req_new_key     = '0;
        req_plain_addr  = '0;
        req_cipher_addr = '0;
        acc_done        = 1'b0;
        m_last          = 1;
        m_kv            = 1'b0;
        m_ko            = 0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_out", {busy, ack, job_done, job_timeout, acc_start, acc_new_key, owner}, 0);
        check("reset_addr", {acc_plain_address, acc_cipher_address}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_job("single", 2'b01, 2'b00, {12'h0AA, 12'h010}, {12'h0BB, 12'h200}, 2'b00, 2'b00, 11, 0, 1'b1);

        // Key reuse, owner change, explicit reload, reuse by new owner.
        run_job("reuse0", 2'b01, 2'b00, 24'($urandom), 24'($urandom), 2'b00, 2'b00, 7, 0, 1'b1);
        run_job("swap1",  2'b10, 2'b00, 24'($urandom), 24'($urandom), 2'b00, 2'b00, 5, 0, 1'b1);
        run_job("force1", 2'b10, 2'b10, 24'($urandom), 24'($urandom), 2'b00, 2'b00, 3, 0, 1'b1);
        run_job("keep1",  2'b10, 2'b00, 24'($urandom), 24'($urandom), 2'b00, 2'b00, 3, 0, 1'b1);

        for (int i = 0; i < 4; i++) begin
            run_job("contend", 2'b11, 2'b00, 24'($urandom), 24'($urandom), 2'b00,
                    (i == 3) ? 2'b00 : 2'b11, 2 + i, 0, 1'b1);
        end

        // Level done: one completion, then no retrigger while held high.
        run_job("level", 2'b01, 2'b00, 24'($urandom), 24'($urandom), 2'b00, 2'b00, 4, 0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            check("level_quiet", {busy, job_done, job_timeout}, 5'b0);
        end
        run_job("fresh", 2'b10, 2'b00, 24'($urandom), 24'($urandom), 2'b00, 2'b00, 9, 3, 1'b1);

        acc_done = 1'b1;
        @(posedge clk); #1;
        check("idle_done", {busy, ack, job_done}, 5'b0);
        acc_done = 1'b0;
        @(posedge clk); #1;
        check("idle_done2", {busy, ack, job_done}, 5'b0);

        run_job("timeout",    2'b01, 2'b00, 24'($urandom), 24'($urandom), 2'b00, 2'b00, -1, 0, 1'b1);
        run_job("after_to",   2'b01, 2'b00, 24'($urandom), 24'($urandom), 2'b00, 2'b00, 6, 0, 1'b1);
        run_job("expiry_tie", 2'b10, 2'b00, 24'($urandom), 24'($urandom), 2'b00, 2'b00, int'(TO_CYC) - 1, 0, 1'b1);

        // A request raised and withdrawn while busy never gets a job.
        run_job("drop", 2'b01, 2'b00, 24'($urandom), 24'($urandom), 2'b10, 2'b00, 8, 0, 1'b1);
        @(posedge clk); #1;
        check("drop_none", {busy, ack, acc_start}, 4'b0);

        // Asynchronous reset in the middle of a job.
        req = 2'b01;
        req_new_key = 2'b00;
        @(posedge clk); #1;
        check("rst_issue", {ack, acc_start}, {onehot(rr_pick(2'b01, m_last)), 1'b1});
        req = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst_async", {busy, ack, acc_start, job_done, job_timeout, acc_new_key}, 0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        m_last = 1;
        m_kv   = 1'b0;
        m_ko   = 0;
        run_job("post_rst", 2'b01, 2'b00, 24'($urandom), 24'($urandom), 2'b00, 2'b00, 5, 0, 1'b1);

        for (int i = 0; i < 16; i++) begin
            run_job("rand", 2'($urandom_range(1, 3)), 2'($urandom), 24'($urandom), 24'($urandom),
                    2'b00, 2'b00, int'($urandom_range(0, 19)), 0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
